// File: rtl/mov_seq_ctrl.sv
// Fetch/decode/execute sequencer for register-move instructions.
// Fetches over a req/ack port, performs one RF read then one RF write per MOV.
module mov_seq_ctrl #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [7:0]      MOV_OPC  = 8'h01,
  parameter logic [7:0]      NOP_OPC  = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RUN,
  input  logic              CLR_ERR,
  output logic              IMEM_REQ,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  input  logic              IMEM_ACK,
  input  logic [15:0]       IMEM_DATA,
  output logic [3:0]        RF_RADDR,
  input  logic [DATA_W-1:0] RF_RDATA,
  output logic              RF_WE,
  output logic [3:0]        RF_WADDR,
  output logic [DATA_W-1:0] RF_WDATA,
  output logic              BUSY,
  output logic              ILLEGAL,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       RETIRED
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_WRITE  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic                illegal_q, illegal_d;
  logic [15:0]         retired_q, retired_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // All strobes are decoded from the registered state, so reset clears them asynchronously.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    IMEM_REQ  = 1'b0;
    RF_RADDR  = '0;
    RF_WE     = 1'b0;
    RF_WADDR  = '0;
    RF_WDATA  = '0;
    case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_ACK) begin
          ir_d    = IMEM_DATA;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[7:0] == MOV_OPC) begin
          state_d = S_READ;
        end else if (ir_q[7:0] == NOP_OPC) begin
          retired_d = retired_q + 16'd1;
          state_d   = RUN ? S_FETCH : S_IDLE;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_READ: begin
        RF_RADDR = ir_q[15:12];
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        RF_RADDR  = ir_q[15:12];
        RF_WE     = 1'b1;
        RF_WADDR  = ir_q[11:8];
        RF_WDATA  = RF_RDATA;
        retired_d = retired_q + 16'd1;
        state_d   = RUN ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        if (CLR_ERR) begin
          illegal_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign ILLEGAL   = illegal_q;
  assign RETIRED   = retired_q;
  assign BUSY      = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule

// File: tb/tb_mov_seq_ctrl.sv
// Directed bench for mov_seq_ctrl: bench-side IMEM with programmable ack delay,
// registered-read RF model, and a second instance checking PC wrap from RESET_PC=FFFF.
module tb_mov_seq_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RUN = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic        IMEM_REQ;
  logic [15:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [15:0] IMEM_DATA;
  logic [3:0]  RF_RADDR;
  logic [15:0] RF_RDATA;
  logic        RF_WE;
  logic [3:0]  RF_WADDR;
  logic [15:0] RF_WDATA;
  logic        BUSY;
  logic        ILLEGAL;
  logic [15:0] PC;
  logic [15:0] RETIRED;

  always #5 CLK = ~CLK;

  mov_seq_ctrl u_dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .CLR_ERR(CLR_ERR),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .RF_RADDR(RF_RADDR), .RF_RDATA(RF_RDATA), .RF_WE(RF_WE), .RF_WADDR(RF_WADDR),
    .RF_WDATA(RF_WDATA), .BUSY(BUSY), .ILLEGAL(ILLEGAL), .PC(PC), .RETIRED(RETIRED)
  );

  // instruction memory: ack after ack_dly wait cycles
  logic [15:0] imem [0:7];
  int          ack_dly = 0;
  int          wcnt;
  assign IMEM_ACK  = IMEM_REQ && (wcnt == ack_dly);
  assign IMEM_DATA = imem[IMEM_ADDR[2:0]];
  always @(posedge CLK or posedge RST) begin
    if (RST) wcnt <= 0;
    else if (IMEM_REQ && !IMEM_ACK) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // register file: read data valid the cycle after the address
  logic [15:0] rf [0:15];
  logic [15:0] rdata_q = 16'h0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = 4'h0;
  logic [15:0] pl_data = 16'h0;
  int          we_cnt = 0;
  logic [3:0]  last_waddr = 4'h0;
  assign RF_RDATA = rdata_q;
  always @(posedge CLK) begin
    rdata_q <= rf[RF_RADDR];
    if (RF_WE) begin
      rf[RF_WADDR] <= RF_WDATA;
      we_cnt       <= we_cnt + 1;
      last_waddr   <= RF_WADDR;
    end
    if (pl_en) rf[pl_addr] <= pl_data;
  end

  // wrap instance: always-NOP zero-wait memory
  logic        w_run = 1'b0;
  logic        w_req;
  logic [15:0] w_addr;
  logic [3:0]  w_raddr, w_waddr;
  logic        w_we, w_busy, w_ill;
  logic [15:0] w_wdata, w_pc, w_ret;
  logic [15:0] w_data  = 16'h0000;
  logic [15:0] w_rdata = 16'h0000;
  logic        w_clr   = 1'b0;

  mov_seq_ctrl #(.RESET_PC(16'hFFFF)) u_wrap (
    .CLK(CLK), .RST(RST), .RUN(w_run), .CLR_ERR(w_clr),
    .IMEM_REQ(w_req), .IMEM_ADDR(w_addr), .IMEM_ACK(w_req), .IMEM_DATA(w_data),
    .RF_RADDR(w_raddr), .RF_RDATA(w_rdata), .RF_WE(w_we), .RF_WADDR(w_waddr),
    .RF_WDATA(w_wdata), .BUSY(w_busy), .ILLEGAL(w_ill), .PC(w_pc), .RETIRED(w_ret)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RUN = 1'b0;
    RST = 1'b1;
    repeat (2) tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  initial begin
    int we0;
    int ticks;
    int unstable;
    logic        prev_req;
    logic        prev_ack;
    logic [15:0] prev_addr;

    for (int i = 0; i < 8; i++) imem[i] = 16'h0000;
    #1 RST = 1'b1;
    repeat (2) tick();

    // reset values
    chk("rst_busy", BUSY, 0);
    chk("rst_pc", PC, 0);
    chk("rst_illegal", ILLEGAL, 0);
    chk("rst_retired", RETIRED, 0);
    chk("rst_req", IMEM_REQ, 0);
    chk("rst_we", RF_WE, 0);
    chk("rst_wdata", RF_WDATA, 0);
    RST = 1'b0;
    tick();

    // MOV r2<-r3, zero wait
    preload(4'd3, 16'hBEEF);
    imem[0] = 16'h3201;
    ack_dly = 0;
    RUN = 1'b1;
    tick();
    chk("t1_fetch_req", IMEM_REQ, 1);
    chk("t1_fetch_addr", IMEM_ADDR, 0);
    chk("t1_busy", BUSY, 1);
    tick();
    chk("t1_decode_pc", PC, 1);
    tick();
    chk("t1_raddr", RF_RADDR, 3);
    chk("t1_read_we", RF_WE, 0);
    tick();
    chk("t1_we", RF_WE, 1);
    chk("t1_waddr", RF_WADDR, 2);
    chk("t1_wdata", RF_WDATA, 16'hBEEF);
    RUN = 1'b0;
    tick();
    chk("t1_retired", RETIRED, 1);
    chk("t1_pc", PC, 1);
    chk("t1_idle_busy", BUSY, 0);
    chk("t1_rf2", rf[2], 16'hBEEF);

    // NOP, MOV r4<-r5, NOP with 2 wait cycles per fetch
    do_reset();
    preload(4'd5, 16'h1234);
    imem[0] = 16'h0000;
    imem[1] = 16'h5401;
    imem[2] = 16'h0000;
    imem[3] = 16'h0002;
    ack_dly = 2;
    we0 = we_cnt;
    unstable = 0;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = 16'h0;
    ticks = 0;
    RUN = 1'b1;
    while (RETIRED != 16'd3 && ticks < 40) begin
      tick();
      ticks++;
      if (IMEM_REQ && prev_req && !prev_ack && IMEM_ADDR != prev_addr) unstable++;
      prev_req  = IMEM_REQ;
      prev_ack  = IMEM_ACK;
      prev_addr = IMEM_ADDR;
    end
    chk("t2_cycles", ticks, 15);
    chk("t2_addr_stable", unstable, 0);
    chk("t2_we_pulses", we_cnt - we0, 1);
    chk("t2_waddr", last_waddr, 4);
    chk("t2_rf4", rf[4], 16'h1234);
    chk("t2_retired", RETIRED, 3);
    chk("t2_pc", PC, 3);
    RUN = 1'b0;

    // illegal opcode, halt, clear
    do_reset();
    imem[0] = 16'h0002;
    imem[1] = 16'h0000;
    ack_dly = 0;
    we0 = we_cnt;
    RUN = 1'b1;
    tick();
    chk("t3_ack", IMEM_ACK, 1);
    tick();
    chk("t3_decode_ill", ILLEGAL, 0);
    tick();
    chk("t3_illegal", ILLEGAL, 1);
    chk("t3_busy", BUSY, 0);
    chk("t3_pc", PC, 1);
    chk("t3_req", IMEM_REQ, 0);
    repeat (3) tick();
    chk("t3_stay_ill", ILLEGAL, 1);
    chk("t3_stay_req", IMEM_REQ, 0);
    chk("t3_no_we", we_cnt - we0, 0);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    chk("t3_clr_ill", ILLEGAL, 0);
    chk("t3_clr_idle_req", IMEM_REQ, 0);
    tick();
    chk("t3_resume_req", IMEM_REQ, 1);
    chk("t3_resume_addr", IMEM_ADDR, 1);
    RUN = 1'b0;

    // RUN dropped during READ
    do_reset();
    preload(4'd7, 16'hA5A5);
    imem[0] = 16'h7101;
    ack_dly = 0;
    RUN = 1'b1;
    repeat (3) tick();
    chk("t4_read_raddr", RF_RADDR, 7);
    RUN = 1'b0;
    tick();
    chk("t4_we", RF_WE, 1);
    chk("t4_waddr", RF_WADDR, 1);
    chk("t4_wdata", RF_WDATA, 16'hA5A5);
    tick();
    chk("t4_busy", BUSY, 0);
    chk("t4_req", IMEM_REQ, 0);
    chk("t4_retired", RETIRED, 1);
    tick();
    chk("t4_still_idle", IMEM_REQ, 0);

    // async reset while in READ
    do_reset();
    imem[0] = 16'h3201;
    we0 = we_cnt;
    RUN = 1'b1;
    repeat (3) tick();
    chk("t5_read_raddr", RF_RADDR, 3);
    chk("t5_pre_pc", PC, 1);
    #2 RST = 1'b1;
    #1;
    chk("t5_raddr", RF_RADDR, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_pc", PC, 0);
    chk("t5_we", RF_WE, 0);
    chk("t5_req", IMEM_REQ, 0);
    tick();
    tick();
    chk("t5_no_write", we_cnt - we0, 0);
    RUN = 1'b0;
    RST = 1'b0;
    tick();

    // PC wrap from RESET_PC=FFFF
    chk("t6_reset_pc", w_pc, 16'hFFFF);
    w_run = 1'b1;
    tick();
    chk("t6_addr_ffff", w_addr, 16'hFFFF);
    tick();
    chk("t6_pc_wrap", w_pc, 0);
    tick();
    chk("t6_next_addr", w_addr, 0);
    chk("t6_next_req", w_req, 1);
    chk("t6_retired", w_ret, 1);
    w_run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mov_seq_ctrl.md
Name: mov_seq_ctrl

Overview:
- Fetch/decode/execute sequencer for the register-move instruction class.
- Fetches a 16-bit instruction word from instruction memory over a req/ack handshake and decodes opcode field I[7:0]; MOV is 8'h01 (I[7:1]==0, I[0]==1), NOP is 8'h00.
- On MOV it sequences one register-file read, then one write.
- Any other opcode raises a sticky illegal-instruction error and parks the sequencer until software clears it.

Parameters:
ADDR_W, 16, width of program counter / IMEM_ADDR
DATA_W, 16, register-file data width
RESET_PC, 0, PC value after reset
MOV_OPC, 8'h01, opcode decoded as MOV
NOP_OPC, 8'h00, opcode decoded as NOP

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
RUN  in  1  level; 1 = keep fetching, 0 = stop at next instruction boundary
CLR_ERR  in  1  one-cycle pulse; leaves HALT, clears ILLEGAL
IMEM_REQ  out  1  fetch request
IMEM_ADDR  out  ADDR_W  fetch address (= PC)
IMEM_ACK  in  1  fetch complete; IMEM_DATA valid this cycle
IMEM_DATA  in  16  instruction word I[15:0]
RF_RADDR  out  4  source register (I[15:12])
RF_RDATA  in  DATA_W  read data, valid the cycle after RF_RADDR is presented
RF_WE  out  1  register write strobe
RF_WADDR  out  4  destination register (I[11:8])
RF_WDATA  out  DATA_W  write data
BUSY  out  1  state != IDLE and state != HALT
ILLEGAL  out  1  sticky illegal-opcode flag
PC  out  ADDR_W  current program counter
RETIRED  out  16  count of retired MOV+NOP instructions, wraps at 16'hFFFF->0

Behaviour:
- Clock and reset: one clock CLK; RST is asynchronous and active-high.
- Reset values: state=IDLE, PC=RESET_PC, IR=0, ILLEGAL=0, RETIRED=0, IMEM_REQ=0, RF_WE=0, RF_RADDR=0, RF_WADDR=0, RF_WDATA=0, BUSY=0.
- RST asserted mid-operation aborts immediately: no RF write completes, an outstanding fetch is dropped, and IMEM_ACK is ignored until state returns to FETCH.
- States: IDLE, FETCH, DECODE, READ, WRITE, HALT.
- IDLE: RUN=1 -> FETCH next cycle.
- FETCH:
  - IMEM_REQ=1 and IMEM_ADDR=PC, held stable until IMEM_ACK; ACK in the same cycle as the first REQ is legal (zero-wait memory).
  - On ACK: IR<=IMEM_DATA, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0), -> DECODE.
  - RUN falling during FETCH does not cancel the fetch.
- DECODE (1 cycle):
  - IR[7:0]==MOV_OPC -> READ.
  - IR[7:0]==NOP_OPC -> RETIRED+1; -> FETCH if RUN else IDLE.
  - Otherwise -> ILLEGAL<=1, -> HALT; PC has already advanced past the bad word.
- READ (1 cycle): RF_RADDR=IR[15:12] -> WRITE.
- WRITE (1 cycle):
  - RF_WE=1, RF_WADDR=IR[11:8], RF_WDATA=RF_RDATA (combinational pass of the value read for IR[15:12]).
  - RETIRED+1; -> FETCH if RUN else IDLE.
  - src==dst is legal and writes the unchanged value.
- RF_WE is 1 only in WRITE: exactly one write per MOV, none for NOP or illegal opcodes.
- HALT: RUN is ignored; CLR_ERR -> ILLEGAL<=0, -> IDLE. CLR_ERR in any other state has no effect.
- Throughput with zero-wait memory: MOV = 4 cycles (FETCH, DECODE, READ, WRITE), NOP = 2 cycles; each IMEM wait cycle adds 1.
- Simultaneous events:
  - CLR_ERR with RUN=1 in HALT goes to IDLE first; FETCH follows one cycle later.
  - RETIRED increments and wraps without an overflow flag.

Test Plan:
- Reset, RUN=1, zero-wait IMEM, word at PC 0 = 16'h3201 (MOV r2<-r3), r3=16'hBEEF -> RF_RADDR=3 in cycle 3, RF_WE=1/RF_WADDR=2/RF_WDATA=16'hBEEF in cycle 4, PC=1, RETIRED=1.
- Program NOP, MOV 16'h5401, NOP with IMEM_ACK delayed 2 cycles per fetch -> IMEM_ADDR stable while REQ high, exactly one RF_WE pulse (WADDR=4), RETIRED=3, PC=3.
- Word 16'h0002 at PC 0 -> ILLEGAL=1 two cycles after ACK, state HALT, BUSY=0, PC=1, no RF_WE; RUN held 1 stays halted; CLR_ERR pulse -> ILLEGAL=0, fetch resumes at PC=1.
- RUN dropped during a MOV's READ cycle -> WRITE still occurs, then IDLE, BUSY=0, IMEM_REQ=0.
- RESET_PC=16'hFFFF, NOP at that address -> PC wraps to 0, next IMEM_ADDR=0.
- RST asserted mid-WRITE-pending (in READ) -> no RF_WE, all outputs at reset values asynchronously, PC=RESET_PC.
